// File: rtl/mm_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mm_mem_arbiter
//
// Shares the single matrix memory port between two masters:
//   rq0 = MM compute engine, rq1 = host loader/unloader.
// Round-robin arbitration with a per-grant burst limit (applied only while the
// other master is waiting) and a lock override. The owner's request fields are
// muxed onto the memory port combinationally. Read responses come back through
// an RD_LAT-deep {valid, tag} pipe so each master sees only its own reads.
//
// Handshake: a master raises rqN_req and holds its request fields stable until
// it sees rqN_gnt. An access happens in every cycle where rqN_gnt && rqN_req.
// A granted master may issue one access per cycle. Read data for an access
// made in cycle t is presented with rqN_rvalid=1 in cycle t+RD_LAT. Writes
// complete in the access cycle and produce no response.
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   rqN_req/lock/we         request, burst-limit override, 1=write 0=read
//   rqN_index/i/j/wdata     matrix select, row, column, write data (2*DW)
//   rqN_gnt                 master N owns the port this cycle
//   rqN_rvalid/rdata        read response for master N (rdata is broadcast)
//   mem_read/write          memory strobes
//   mem_index/i/j/wdata     memory address and write data (0 when idle)
//   mem_rdata               memory read data, valid RD_LAT after mem_read
//   dbg_own                 owner state: 0=NONE, 1=OWN0, 2=OWN1
// -----------------------------------------------------------------------------
module mm_mem_arbiter #(
  parameter int AW     = 20,
  parameter int DW     = 20,
  parameter int BURST  = 8,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            rq0_req,
  input  logic            rq0_lock,
  input  logic            rq0_we,
  input  logic            rq0_index,
  input  logic [AW-1:0]   rq0_i,
  input  logic [AW-1:0]   rq0_j,
  input  logic [2*DW-1:0] rq0_wdata,
  output logic            rq0_gnt,
  output logic            rq0_rvalid,
  output logic [DW-1:0]   rq0_rdata,

  input  logic            rq1_req,
  input  logic            rq1_lock,
  input  logic            rq1_we,
  input  logic            rq1_index,
  input  logic [AW-1:0]   rq1_i,
  input  logic [AW-1:0]   rq1_j,
  input  logic [2*DW-1:0] rq1_wdata,
  output logic            rq1_gnt,
  output logic            rq1_rvalid,
  output logic [DW-1:0]   rq1_rdata,

  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_index,
  output logic [AW-1:0]   mem_i,
  output logic [AW-1:0]   mem_j,
  output logic [2*DW-1:0] mem_wdata,
  input  logic [DW-1:0]   mem_rdata,

  output logic [1:0]      dbg_own
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } own_t;

  own_t              own;
  logic              last;     // master that most recently released; loses the next tie
  logic [CW-1:0]     cnt;      // accesses in current grant, saturating at BURST-1
  logic [RD_LAT-1:0] pipe_v;   // read return pipe: valid
  logic [RD_LAT-1:0] pipe_t;   // read return pipe: tag (1 = rq1)

  logic acc0, acc1;
  logic cur_req, oth_req, cur_lock;

  assign rq0_gnt = (own == OWN_0);
  assign rq1_gnt = (own == OWN_1);
  assign dbg_own = own;

  assign acc0 = rq0_gnt & rq0_req;
  assign acc1 = rq1_gnt & rq1_req;

  // Owner's inputs onto the memory port; everything zero when no access.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_index = 1'b0;
    mem_i     = '0;
    mem_j     = '0;
    mem_wdata = '0;
    if (acc0) begin
      mem_read  = ~rq0_we;
      mem_write = rq0_we;
      mem_index = rq0_index;
      mem_i     = rq0_i;
      mem_j     = rq0_j;
      mem_wdata = rq0_wdata;
    end else if (acc1) begin
      mem_read  = ~rq1_we;
      mem_write = rq1_we;
      mem_index = rq1_index;
      mem_i     = rq1_i;
      mem_j     = rq1_j;
      mem_wdata = rq1_wdata;
    end
  end

  // Current owner's view of the request lines, to share one transition path.
  always_comb begin
    cur_req  = 1'b0;
    oth_req  = 1'b0;
    cur_lock = 1'b0;
    if (own == OWN_0) begin
      cur_req  = rq0_req;
      oth_req  = rq1_req;
      cur_lock = rq0_lock;
    end else if (own == OWN_1) begin
      cur_req  = rq1_req;
      oth_req  = rq0_req;
      cur_lock = rq1_lock;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own    <= OWN_NONE;
      last   <= 1'b1;
      cnt    <= '0;
      pipe_v <= '0;
      pipe_t <= '0;
    end else begin
      for (int s = RD_LAT - 1; s > 0; s--) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_t[s] <= pipe_t[s-1];
      end
      pipe_v[0] <= mem_read;
      pipe_t[0] <= acc1;

      case (own)
        OWN_NONE: begin
          cnt <= '0;
          if (rq0_req && rq1_req) own <= last ? OWN_0 : OWN_1;
          else if (rq0_req)       own <= OWN_0;
          else if (rq1_req)       own <= OWN_1;
        end
        OWN_0, OWN_1: begin
          if (!cur_req) begin
            // Release: hand straight over if the other master waits.
            last <= (own == OWN_1);
            cnt  <= '0;
            if (oth_req) own <= (own == OWN_0) ? OWN_1 : OWN_0;
            else         own <= OWN_NONE;
          end else if (!cur_lock && cnt == CNT_MAX && oth_req) begin
            // Burst exhausted with a waiter: this access completes, then switch.
            last <= (own == OWN_1);
            cnt  <= '0;
            own  <= (own == OWN_0) ? OWN_1 : OWN_0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: own <= OWN_NONE;
      endcase
    end
  end

  assign rq0_rvalid = pipe_v[RD_LAT-1] & ~pipe_t[RD_LAT-1];
  assign rq1_rvalid = pipe_v[RD_LAT-1] &  pipe_t[RD_LAT-1];
  assign rq0_rdata  = mem_rdata;
  assign rq1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mm_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mm_mem_arbiter
//
// Bench for mm_mem_arbiter. Inputs are applied on the falling edge, outputs
// are sampled 1 ns later, and the reference model advances at the rising edge.
// The model tracks ownership as an integer, counts accesses per grant without
// bound, and keeps outstanding reads in exp_q as {tag, due_cycle}.
// -----------------------------------------------------------------------------
module tb_mm_mem_arbiter;

  localparam int AW     = 20;
  localparam int DW     = 20;
  localparam int BURST  = 8;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic            req0, req1, lock0, lock1, we0, we1, idx0, idx1;
    logic [AW-1:0]   i0, j0, i1, j1;
    logic [2*DW-1:0] wd0, wd1;
  } in_t;

  typedef struct {
    in_t           in;
    logic          g0, g1, rd, wr;
    logic [AW-1:0] mi, mj;
    logic          rv0, rv1;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic            rq0_req, rq0_lock, rq0_we, rq0_index;
  logic [AW-1:0]   rq0_i, rq0_j;
  logic [2*DW-1:0] rq0_wdata;
  logic            rq0_gnt, rq0_rvalid;
  logic [DW-1:0]   rq0_rdata;
  logic            rq1_req, rq1_lock, rq1_we, rq1_index;
  logic [AW-1:0]   rq1_i, rq1_j;
  logic [2*DW-1:0] rq1_wdata;
  logic            rq1_gnt, rq1_rvalid;
  logic [DW-1:0]   rq1_rdata;
  logic            mem_read, mem_write, mem_index;
  logic [AW-1:0]   mem_i, mem_j;
  logic [2*DW-1:0] mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [1:0]      dbg_own;

  always #5 clk = ~clk;

  mm_mem_arbiter #(.AW(AW), .DW(DW), .BURST(BURST), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .rq0_req(rq0_req), .rq0_lock(rq0_lock), .rq0_we(rq0_we), .rq0_index(rq0_index),
    .rq0_i(rq0_i), .rq0_j(rq0_j), .rq0_wdata(rq0_wdata),
    .rq0_gnt(rq0_gnt), .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
    .rq1_req(rq1_req), .rq1_lock(rq1_lock), .rq1_we(rq1_we), .rq1_index(rq1_index),
    .rq1_i(rq1_i), .rq1_j(rq1_j), .rq1_wdata(rq1_wdata),
    .rq1_gnt(rq1_gnt), .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_index(mem_index),
    .mem_i(mem_i), .mem_j(mem_j), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_own(dbg_own)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_own;     // -1 none, 0 or 1
  int          m_last;
  int          m_uses;    // accesses in current grant
  int          m_cycle;
  logic [32:0] exp_q[$];  // {tag, due_cycle}
  in_t         cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    rq0_req = v.req0; rq0_lock = v.lock0; rq0_we = v.we0; rq0_index = v.idx0;
    rq0_i = v.i0; rq0_j = v.j0; rq0_wdata = v.wd0;
    rq1_req = v.req1; rq1_lock = v.lock1; rq1_we = v.we1; rq1_index = v.idx1;
    rq1_i = v.i1; rq1_j = v.j1; rq1_wdata = v.wd1;
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic model_compare();
    logic            acc, e_rd, e_wr, e_idx, e_rv0, e_rv1;
    logic [AW-1:0]   e_i, e_j;
    logic [2*DW-1:0] e_wd;
    acc = (m_own == 0 && cur.req0) || (m_own == 1 && cur.req1);
    e_rd = 0; e_wr = 0; e_idx = 0; e_i = '0; e_j = '0; e_wd = '0;
    if (acc && m_own == 0) begin
      e_rd = !cur.we0; e_wr = cur.we0; e_idx = cur.idx0; e_i = cur.i0; e_j = cur.j0; e_wd = cur.wd0;
    end else if (acc) begin
      e_rd = !cur.we1; e_wr = cur.we1; e_idx = cur.idx1; e_i = cur.i1; e_j = cur.j1; e_wd = cur.wd1;
    end
    e_rv0 = 0; e_rv1 = 0;
    if (exp_q.size() > 0 && int'(exp_q[0][31:0]) == m_cycle) begin
      e_rv0 = !exp_q[0][32];
      e_rv1 = exp_q[0][32];
    end
    check("gnt0", 64'(rq0_gnt), 64'(m_own == 0 && !reset));
    check("gnt1", 64'(rq1_gnt), 64'(m_own == 1 && !reset));
    check("mem_read", 64'(mem_read), 64'(e_rd));
    check("mem_write", 64'(mem_write), 64'(e_wr));
    check("mem_index", 64'(mem_index), 64'(e_idx));
    check("mem_i", 64'(mem_i), 64'(e_i));
    check("mem_j", 64'(mem_j), 64'(e_j));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    check("rvalid0", 64'(rq0_rvalid), 64'(e_rv0));
    check("rvalid1", 64'(rq1_rvalid), 64'(e_rv1));
    if (e_rv0) check("rdata0", 64'(rq0_rdata), 64'(mem_rdata));
    if (e_rv1) check("rdata1", 64'(rq1_rdata), 64'(mem_rdata));
  endtask

  task automatic model_reset();
    m_own = -1; m_last = 1; m_uses = 0; m_cycle = 0;
    exp_q.delete();
  endtask

  // Arbitration rules applied at a rising edge.
  task automatic model_update();
    logic r0, r1, rk, ro, lk, acc;
    int o;
    o = m_own; r0 = cur.req0; r1 = cur.req1;
    acc = (o == 0 && r0) || (o == 1 && r1);
    if (exp_q.size() > 0 && int'(exp_q[0][31:0]) == m_cycle) void'(exp_q.pop_front());
    if (acc && !((o == 0) ? cur.we0 : cur.we1))
      exp_q.push_back({logic'(o == 1), 32'(m_cycle + RD_LAT)});
    if (o < 0) begin
      m_uses = 0;
      if (r0 && r1) m_own = (m_last == 1) ? 0 : 1;
      else if (r0)  m_own = 0;
      else if (r1)  m_own = 1;
    end else begin
      rk = (o == 0) ? r0 : r1;
      ro = (o == 0) ? r1 : r0;
      lk = (o == 0) ? cur.lock0 : cur.lock1;
      if (!rk) begin
        m_last = o; m_uses = 0;
        m_own = ro ? 1 - o : -1;
      end else begin
        m_uses++;
        if (!lk && m_uses >= BURST && ro) begin
          m_last = o; m_uses = 0; m_own = 1 - o;
        end
      end
    end
    m_cycle++;
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic apply(input in_t v);
    cur = v;
    drive(v);
    mem_rdata = DW'($urandom);
    #1;
    model_compare();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    in_t idle;
    idle = '0;
    reset = 1'b1;
    model_reset();
    apply(idle);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.req0 = ($urandom_range(0, 3) != 0); v.req1 = ($urandom_range(0, 3) != 0);
    v.lock0 = ($urandom_range(0, 5) == 0); v.lock1 = ($urandom_range(0, 5) == 0);
    v.we0 = 1'($urandom); v.we1 = 1'($urandom);
    v.idx0 = 1'($urandom); v.idx1 = 1'($urandom);
    v.i0 = AW'($urandom); v.j0 = AW'($urandom); v.i1 = AW'($urandom); v.j1 = AW'($urandom);
    v.wd0 = {8'($urandom), $urandom}; v.wd1 = {8'($urandom), $urandom};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[8];
    in_t  v, rd0, wr1;

    reset = 1'b1;
    cur = '0;
    drive(cur);
    mem_rdata = '0;
    model_reset();
    @(negedge clk);

    // Vector table: rq0 read (index 0, i=2, j=3), then rq1 write (i=5, j=6).
    rd0 = '0; rd0.req0 = 1; rd0.i0 = 2; rd0.j0 = 3;
    wr1 = '0; wr1.req1 = 1; wr1.we1 = 1; wr1.idx1 = 1; wr1.i1 = 5; wr1.j1 = 6; wr1.wd1 = 40'hABCDE_01234;
    tbl[0] = '{rd0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{rd0,  1, 0, 1, 0, 2, 3, 0, 0};
    tbl[2] = '{'0,   1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{'0,   0, 0, 0, 0, 0, 0, 1, 0};
    tbl[4] = '{wr1,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{wr1,  0, 1, 0, 1, 5, 6, 0, 0};
    tbl[6] = '{'0,   0, 1, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{'0,   0, 0, 0, 0, 0, 0, 0, 0};

    apply_reset();
    for (int k = 0; k < 8; k++) begin
      apply(tbl[k].in);
      check($sformatf("tbl%0d_gnt0", k), 64'(rq0_gnt), 64'(tbl[k].g0));
      check($sformatf("tbl%0d_gnt1", k), 64'(rq1_gnt), 64'(tbl[k].g1));
      check($sformatf("tbl%0d_rd", k), 64'(mem_read), 64'(tbl[k].rd));
      check($sformatf("tbl%0d_wr", k), 64'(mem_write), 64'(tbl[k].wr));
      check($sformatf("tbl%0d_i", k), 64'(mem_i), 64'(tbl[k].mi));
      check($sformatf("tbl%0d_j", k), 64'(mem_j), 64'(tbl[k].mj));
      check($sformatf("tbl%0d_rv0", k), 64'(rq0_rvalid), 64'(tbl[k].rv0));
      check($sformatf("tbl%0d_rv1", k), 64'(rq1_rvalid), 64'(tbl[k].rv1));
      advance();
    end

    // Both request from reset: 8 rq0 reads, 8 rq1 writes, back to rq0.
    // rq0's read in its last burst cycle returns during rq1's grant.
    apply_reset();
    for (int t = 0; t < 18; t++) begin
      v = '0;
      v.req0 = 1; v.req1 = 1; v.idx0 = 1; v.i0 = AW'(t); v.j0 = AW'(t + 1);
      v.we1 = 1; v.i1 = AW'(100 + t); v.wd1 = 40'h12345_6789A;
      apply(v);
      check($sformatf("burst_gnt0_t%0d", t), 64'(rq0_gnt), 64'((t >= 1 && t <= 8) || t == 17));
      check($sformatf("burst_gnt1_t%0d", t), 64'(rq1_gnt), 64'(t >= 9 && t <= 16));
      if (t == 9) begin
        check("switch_mem_write", 64'(mem_write), 64'(1));
        check("switch_mem_wdata", 64'(mem_wdata), 64'(40'h12345_6789A));
      end
      if (t == 8 + RD_LAT) begin
        check("last_read_rv0", 64'(rq0_rvalid), 64'(1));
        check("last_read_rv1", 64'(rq1_rvalid), 64'(0));
      end
      if (t == 9 + RD_LAT) check("after_switch_rv0", 64'(rq0_rvalid), 64'(0));
      advance();
    end

    // rq1 locked for 20 accesses with rq0 waiting; then release with no bubble.
    apply_reset();
    for (int t = 0; t < 23; t++) begin
      v = '0;
      v.req1 = (t <= 20); v.lock1 = 1; v.req0 = (t >= 1);
      v.i1 = AW'(t); v.i0 = 7;
      apply(v);
      check($sformatf("lock_gnt1_t%0d", t), 64'(rq1_gnt), 64'(t >= 1 && t <= 21));
      check($sformatf("lock_gnt0_t%0d", t), 64'(rq0_gnt), 64'(t == 22));
      advance();
    end

    // Reset while a read is in flight: no response, rq0 wins the next tie.
    apply_reset();
    rd0 = '0; rd0.req0 = 1; rd0.i0 = 9;
    apply(rd0); advance();
    apply(rd0);
    check("inflight_read_issued", 64'(mem_read), 64'(1));
    advance();
    apply_reset();
    v = '0; v.req0 = 1; v.req1 = 1;
    for (int t = 0; t < 3; t++) begin
      apply(v);
      check($sformatf("post_reset_rv0_t%0d", t), 64'(rq0_rvalid), 64'(0));
      check($sformatf("post_reset_gnt0_t%0d", t), 64'(rq0_gnt), 64'(t >= 1));
      check($sformatf("post_reset_gnt1_t%0d", t), 64'(rq1_gnt), 64'(0));
      advance();
    end

    // Random traffic against the model, with occasional mid-run resets.
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        apply(rand_in());
        advance();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
